multicycle_control_mips: RTL and testbench
==========================================

MULTICYCLE_CONTROL_MIPS -- requirements
Module: multicycle_control_mips

Interface
REQ-001 Parameters SHALL be one per line:
- alu_con_width, 3, ALU control width
- op_width, 6, opcode width
- funct_width, 6, funct field width
- state_width, 4, state register width
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- op  in  6  opcode, instr[31:26]
- funct  in  6  funct, instr[5:0]
- zero_flag  in  1  ALU zero
- mem_rdy  in  1  memory access completes this cycle
- iord  out  1  memory address select: 0=PC, 1=ALU result register
- mem_wr  out  1  memory write strobe
- ir_wr  out  1  instruction register load
- pc_en  out  1  PC load
- reg_dst  out  1  register destination: 0=rt, 1=rd
- mem_to_reg  out  1  write-back source: 1=memory data
- reg_wr  out  1  register file write
- alu_src_a  out  1  ALU source A: 0=PC, 1=regA
- alu_src_b  out  2  ALU source B: 00=regB, 01=4, 10=signImm, 11=signImm<<2
- pc_src  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- alu_con  out  3  ALU operation
- illegal_op  out  1  unsupported opcode seen in DECODE
- state  out  4  current state, debug

Function
REQ-003 The state register SHALL be the only storage element; all outputs SHALL be combinational from state, op, funct, zero_flag, mem_rdy and rst.
REQ-004 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-005 Transitions SHALL be:
- FETCH: stays while mem_rdy=0; goes to DECODE when mem_rdy=1.
- DECODE: by op. 100011/101011 go to MEMADR; 000000 goes to EXEC; 000100 goes to BEQ; 001000 goes to ADDIEX; 000010 goes to JUMP; any other op goes to FETCH.
- MEMADR: op=100011 goes to MEMRD, otherwise MEMWR.
- MEMRD: stays while mem_rdy=0; goes to MEMWB when mem_rdy=1.
- MEMWR: stays while mem_rdy=0; goes to FETCH when mem_rdy=1.
- EXEC goes to ALUWB; ADDIEX goes to ADDIWB.
- MEMWB, ALUWB, ADDIWB, BEQ and JUMP go to FETCH.
REQ-006 Every output not listed for a state SHALL be 0 in that state. Per-state outputs SHALL be:
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_con=010, pc_src=00; ir_wr=mem_rdy, pc_en=mem_rdy.
- DECODE: alu_src_a=0, alu_src_b=11, alu_con=010; illegal_op=1 when op is unsupported.
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_con=010.
- MEMRD: iord=1.
- MEMWR: iord=1, mem_wr=1, held for every waiting cycle.
- MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0.
- EXEC: alu_src_a=1, alu_src_b=00, alu_con per REQ-007.
- ALUWB: reg_wr=1, reg_dst=1, mem_to_reg=0.
- ADDIWB: reg_wr=1, reg_dst=0.
- BEQ: alu_src_a=1, alu_src_b=00, alu_con=110, pc_src=01, pc_en=zero_flag.
- JUMP: pc_src=10, pc_en=1.
REQ-007 In EXEC, alu_con SHALL decode funct as: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Any other funct SHALL give 010, with no illegal_op.
REQ-008 Instruction latency in cycles SHALL be:
- lw: 5; sw: 4; R-type: 4; addi: 4; beq: 3; j: 3.
- Each cycle mem_rdy=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-009 An illegal opcode SHALL cost 2 cycles and SHALL produce no reg_wr, mem_wr or pc_en beyond its FETCH.
REQ-010 pc_en, ir_wr, reg_wr and mem_wr SHALL never be 1 in the same cycle as rst=1.

Reset
REQ-011 Asserting rst SHALL force state to FETCH immediately, without waiting for clk, including in the middle of an instruction. The in-flight instruction SHALL be abandoned with no further writes.
REQ-012 While rst=1, all outputs SHALL equal the FETCH values with ir_wr=pc_en=0.
REQ-013 On the first rising edge after rst falls, the FSM SHALL evaluate from FETCH.

Verification
REQ-014 lw (op=100011), mem_rdy=1 throughout -> states 0,1,2,3,4,0; reg_wr=1 with mem_to_reg=1 only in state 4.
REQ-015 sw (op=101011), mem_rdy low for 2 cycles in MEMWR -> mem_wr=1 for 3 consecutive cycles with iord=1; returns to FETCH after the cycle mem_rdy=1.
REQ-016 R-type (op=000000, funct=101010) -> alu_con=111 in EXEC; ALUWB has reg_wr=1, reg_dst=1.
REQ-017 beq -> pc_en=1 in BEQ when zero_flag=1 and pc_en=0 when zero_flag=0; both cases return to FETCH in 3 cycles.
REQ-018 op=111111 -> illegal_op=1 for exactly one cycle in DECODE; next state is FETCH with no writes.
REQ-019 rst pulsed asynchronously mid-MEMRD -> state=0 before the next clk edge; mem_wr/reg_wr stay 0; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_control_mips.sv
// -----------------------------------------------------------------------------
// multicycle_control_mips
//
// Control unit for a multicycle MIPS datapath. It supports lw, sw, R-type
// (add/sub/and/or/slt), addi, beq and j. The only storage element is the state
// register. Every control output is decoded combinationally from the state,
// the instruction fields, zero_flag, mem_rdy and rst.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   op          in   opcode, instr[31:26]
//   funct       in   funct field, instr[5:0]
//   zero_flag   in   ALU zero result
//   mem_rdy     in   memory access completes this cycle
//   iord        out  memory address select: 0=PC, 1=ALU result register
//   mem_wr      out  memory write strobe
//   ir_wr       out  instruction register load
//   pc_en       out  PC load
//   reg_dst     out  register destination: 0=rt, 1=rd
//   mem_to_reg  out  write-back source: 1=memory data
//   reg_wr      out  register file write
//   alu_src_a   out  ALU source A: 0=PC, 1=regA
//   alu_src_b   out  ALU source B: 00=regB, 01=4, 10=signImm, 11=signImm<<2
//   pc_src      out  PC source: 00=ALU, 01=ALUOut, 10=jump target
//   alu_con     out  ALU operation
//   illegal_op  out  unsupported opcode seen in DECODE
//   state       out  current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_mips #(
  parameter int alu_con_width = 3,
  parameter int op_width      = 6,
  parameter int funct_width   = 6,
  parameter int state_width   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [op_width-1:0]      op,
  input  logic [funct_width-1:0]   funct,
  input  logic                     zero_flag,
  input  logic                     mem_rdy,
  output logic                     iord,
  output logic                     mem_wr,
  output logic                     ir_wr,
  output logic                     pc_en,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     reg_wr,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               pc_src,
  output logic [alu_con_width-1:0] alu_con,
  output logic                     illegal_op,
  output logic [state_width-1:0]   state
);

  typedef enum logic [state_width-1:0] {
    s_fetch  = 0,
    s_decode = 1,
    s_memadr = 2,
    s_memrd  = 3,
    s_memwb  = 4,
    s_memwr  = 5,
    s_exec   = 6,
    s_aluwb  = 7,
    s_beq    = 8,
    s_addiex = 9,
    s_addiwb = 10,
    s_jump   = 11
  } state_t;

  localparam logic [op_width-1:0] op_lw    = 6'b100011;
  localparam logic [op_width-1:0] op_sw    = 6'b101011;
  localparam logic [op_width-1:0] op_rtype = 6'b000000;
  localparam logic [op_width-1:0] op_beq   = 6'b000100;
  localparam logic [op_width-1:0] op_addi  = 6'b001000;
  localparam logic [op_width-1:0] op_j     = 6'b000010;

  localparam logic [alu_con_width-1:0] alu_and = 3'b000;
  localparam logic [alu_con_width-1:0] alu_or  = 3'b001;
  localparam logic [alu_con_width-1:0] alu_add = 3'b010;
  localparam logic [alu_con_width-1:0] alu_sub = 3'b110;
  localparam logic [alu_con_width-1:0] alu_slt = 3'b111;

  state_t state_q;
  state_t state_d;

  // NOTE: sequential state uses non-blocking assignments so that every
  // process reading state_q sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= s_fetch;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path
    // through this block can leave a value unassigned and infer a latch.
    state_d    = s_fetch;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_en      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_con    = '0;
    illegal_op = 1'b0;

    case (state_q)
      s_fetch: begin
        // PC + 4 is computed every cycle. The IR and PC load only once the
        // memory read completes.
        alu_src_b = 2'b01;
        alu_con   = alu_add;
        ir_wr     = mem_rdy;
        pc_en     = mem_rdy;
        state_d   = mem_rdy ? s_decode : s_fetch;
      end
      s_decode: begin
        // Branch target (PC + imm<<2) is precomputed speculatively.
        alu_src_b = 2'b11;
        alu_con   = alu_add;
        case (op)
          op_lw, op_sw: state_d = s_memadr;
          op_rtype:     state_d = s_exec;
          op_beq:       state_d = s_beq;
          op_addi:      state_d = s_addiex;
          op_j:         state_d = s_jump;
          default: begin
            illegal_op = 1'b1;
            state_d    = s_fetch;
          end
        endcase
      end
      s_memadr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_con   = alu_add;
        state_d   = (op == op_lw) ? s_memrd : s_memwr;
      end
      s_memrd: begin
        iord    = 1'b1;
        state_d = mem_rdy ? s_memwb : s_memrd;
      end
      s_memwb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = s_fetch;
      end
      s_memwr: begin
        // The write strobe is held until the memory accepts it.
        iord    = 1'b1;
        mem_wr  = 1'b1;
        state_d = mem_rdy ? s_fetch : s_memwr;
      end
      s_exec: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100000: alu_con = alu_add;
          6'b100010: alu_con = alu_sub;
          6'b100100: alu_con = alu_and;
          6'b100101: alu_con = alu_or;
          6'b101010: alu_con = alu_slt;
          default:   alu_con = alu_add;
        endcase
        state_d = s_aluwb;
      end
      s_aluwb: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        state_d = s_fetch;
      end
      s_beq: begin
        alu_src_a = 1'b1;
        alu_con   = alu_sub;
        pc_src    = 2'b01;
        pc_en     = zero_flag;
        state_d   = s_fetch;
      end
      s_addiex: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_con   = alu_add;
        state_d   = s_addiwb;
      end
      s_addiwb: begin
        reg_wr  = 1'b1;
        state_d = s_fetch;
      end
      s_jump: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = s_fetch;
      end
      default: state_d = s_fetch;
    endcase

    // The state register is already FETCH during reset. These gates stop
    // any write strobe from being seen while rst is high, including in the
    // delta between rst rising and the register clearing.
    if (rst) begin
      ir_wr  = 1'b0;
      pc_en  = 1'b0;
      reg_wr = 1'b0;
      mem_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_mips.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_mips
//
// Scoreboard bench for multicycle_control_mips. The stimulus drives one cycle
// at a time and pushes the hand-derived output vector expected for that cycle.
// A monitor pops an entry at each falling edge, or on an explicit event after
// an asynchronous reset, and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_control_mips;

  typedef struct packed {
    logic [3:0] state;
    logic       iord;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_con;
    logic       illegal_op;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_item_t;

  localparam logic [5:0] op_lw   = 6'b100011;
  localparam logic [5:0] op_sw   = 6'b101011;
  localparam logic [5:0] op_r    = 6'b000000;
  localparam logic [5:0] op_beq  = 6'b000100;
  localparam logic [5:0] op_addi = 6'b001000;
  localparam logic [5:0] op_j    = 6'b000010;
  localparam logic [5:0] op_bad  = 6'b111111;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_rdy;
  logic       iord, mem_wr, ir_wr, pc_en, reg_dst, mem_to_reg, reg_wr;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_con;
  logic [3:0] state;

  sb_item_t sb[$];
  event      sample_ev;
  int        checks = 0;
  int        errors = 0;

  multicycle_control_mips dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero_flag  (zero_flag),
    .mem_rdy    (mem_rdy),
    .iord       (iord),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .pc_en      (pc_en),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_wr     (reg_wr),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_con    (alu_con),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors, one per state, taken from the state table.
  function automatic exp_t e_base(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = e_base(4'd0);
    e.alu_src_b = 2'b01; e.alu_con = 3'b010; e.ir_wr = rdy; e.pc_en = rdy;
    return e;
  endfunction

  function automatic exp_t e_rst();
    return e_fetch(1'b0);
  endfunction

  function automatic exp_t e_decode(input logic ill);
    exp_t e = e_base(4'd1);
    e.alu_src_b = 2'b11; e.alu_con = 3'b010; e.illegal_op = ill;
    return e;
  endfunction

  function automatic exp_t e_addr(input logic [3:0] s);
    exp_t e = e_base(s);
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_con = 3'b010;
    return e;
  endfunction

  function automatic exp_t e_memrd();
    exp_t e = e_base(4'd3);
    e.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwb();
    exp_t e = e_base(4'd4);
    e.reg_wr = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwr();
    exp_t e = e_base(4'd5);
    e.iord = 1'b1; e.mem_wr = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [2:0] con);
    exp_t e = e_base(4'd6);
    e.alu_src_a = 1'b1; e.alu_con = con;
    return e;
  endfunction

  function automatic exp_t e_aluwb();
    exp_t e = e_base(4'd7);
    e.reg_wr = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_beq(input logic zf);
    exp_t e = e_base(4'd8);
    e.alu_src_a = 1'b1; e.alu_con = 3'b110; e.pc_src = 2'b01; e.pc_en = zf;
    return e;
  endfunction

  function automatic exp_t e_addiwb();
    exp_t e = e_base(4'd10);
    e.reg_wr = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_jump();
    exp_t e = e_base(4'd11);
    e.pc_src = 2'b10; e.pc_en = 1'b1;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.state = state; a.iord = iord; a.mem_wr = mem_wr; a.ir_wr = ir_wr;
    a.pc_en = pc_en; a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg;
    a.reg_wr = reg_wr; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
    a.pc_src = pc_src; a.alu_con = alu_con; a.illegal_op = illegal_op;
    return a;
  endfunction

  // Monitor: compare one scoreboard entry per sample point.
  initial begin
    sb_item_t it;
    exp_t     act;
    forever begin
      @(negedge clk or sample_ev);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = sample();
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                   it.name, act, act.state, it.e, it.e.state);
        end
      end
    end
  end

  // Drive inputs for the current cycle, queue its expectation, then advance
  // past the rising edge that ends it.
  task automatic cyc(input string n, input logic [5:0] o, input logic [5:0] f,
                     input logic rdy, input logic zf, input exp_t e);
    sb_item_t it;
    op = o; funct = f; mem_rdy = rdy; zero_flag = zf;
    it.name = n; it.e = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string n, input logic [5:0] o, input logic [5:0] f,
                       input int stalls);
    for (int i = 0; i < stalls; i++) cyc({n, " fetch wait"}, o, f, 1'b0, 1'b0, e_fetch(1'b0));
    cyc({n, " fetch"}, o, f, 1'b1, 1'b0, e_fetch(1'b1));
  endtask

  task automatic i_lw(input int fs, input int ms);
    fetch("lw", op_lw, 6'h00, fs);
    cyc("lw decode", op_lw, 6'h00, 1'b0, 1'b0, e_decode(1'b0));
    cyc("lw memadr", op_lw, 6'h00, 1'b0, 1'b0, e_addr(4'd2));
    for (int i = 0; i < ms; i++) cyc("lw memrd wait", op_lw, 6'h00, 1'b0, 1'b0, e_memrd());
    cyc("lw memrd", op_lw, 6'h00, 1'b1, 1'b0, e_memrd());
    cyc("lw memwb", op_lw, 6'h00, 1'b0, 1'b0, e_memwb());
  endtask

  task automatic i_sw(input int fs, input int ws);
    fetch("sw", op_sw, 6'h00, fs);
    cyc("sw decode", op_sw, 6'h00, 1'b0, 1'b0, e_decode(1'b0));
    cyc("sw memadr", op_sw, 6'h00, 1'b0, 1'b0, e_addr(4'd2));
    for (int i = 0; i < ws; i++) cyc("sw memwr wait", op_sw, 6'h00, 1'b0, 1'b0, e_memwr());
    cyc("sw memwr", op_sw, 6'h00, 1'b1, 1'b0, e_memwr());
  endtask

  task automatic i_r(input logic [5:0] f, input logic [2:0] con);
    fetch("rtype", op_r, f, 0);
    cyc("rtype decode", op_r, f, 1'b0, 1'b0, e_decode(1'b0));
    cyc("rtype exec", op_r, f, 1'b0, 1'b0, e_exec(con));
    cyc("rtype aluwb", op_r, f, 1'b0, 1'b0, e_aluwb());
  endtask

  task automatic i_addi();
    fetch("addi", op_addi, 6'h15, 0);
    cyc("addi decode", op_addi, 6'h15, 1'b0, 1'b0, e_decode(1'b0));
    cyc("addi ex", op_addi, 6'h15, 1'b0, 1'b0, e_addr(4'd9));
    cyc("addi wb", op_addi, 6'h15, 1'b0, 1'b0, e_addiwb());
  endtask

  task automatic i_beq(input logic zf);
    fetch("beq", op_beq, 6'h00, 0);
    cyc("beq decode", op_beq, 6'h00, 1'b0, zf, e_decode(1'b0));
    cyc("beq branch", op_beq, 6'h00, 1'b0, zf, e_beq(zf));
  endtask

  task automatic i_j();
    fetch("j", op_j, 6'h00, 0);
    cyc("j decode", op_j, 6'h00, 1'b0, 1'b0, e_decode(1'b0));
    cyc("j jump", op_j, 6'h00, 1'b0, 1'b0, e_jump());
  endtask

  task automatic i_bad();
    fetch("illegal", op_bad, 6'h00, 0);
    cyc("illegal decode", op_bad, 6'h00, 1'b1, 1'b0, e_decode(1'b1));
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d required to finish", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; op = '0; funct = '0; zero_flag = 1'b0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    // With rst high and mem_rdy high, the FETCH strobes must remain low.
    cyc("reset hold", op_lw, 6'h00, 1'b1, 1'b0, e_rst());
    rst = 1'b0;

    i_lw(0, 0);            // 0,1,2,3,4
    i_sw(1, 2);            // fetch stall, then three cycles of mem_wr
    i_r(6'b101010, 3'b111);
    i_r(6'b100010, 3'b110);
    i_r(6'b100100, 3'b000);
    i_r(6'b100101, 3'b001);
    i_r(6'b000111, 3'b010); // unknown funct falls back to add
    i_addi();
    i_beq(1'b1);
    i_beq(1'b0);
    i_j();
    i_bad();               // followed directly by a FETCH check below
    i_lw(0, 1);            // one MEMRD stall

    // Asynchronous reset in the middle of MEMRD.
    fetch("lw abort", op_lw, 6'h00, 0);
    cyc("lw abort decode", op_lw, 6'h00, 1'b0, 1'b0, e_decode(1'b0));
    cyc("lw abort memadr", op_lw, 6'h00, 1'b0, 1'b0, e_addr(4'd2));
    begin
      sb_item_t it;
      op = op_lw; mem_rdy = 1'b0; zero_flag = 1'b0;
      it.name = "lw abort memrd"; it.e = e_memrd();
      sb.push_back(it);
      @(negedge clk);
      #3;
      rst = 1'b1;           // well before the next rising edge
      #1;
      it.name = "async reset mid memrd"; it.e = e_rst();
      sb.push_back(it);
      ->sample_ev;
      @(posedge clk);
      #1;
    end
    cyc("reset held", op_lw, 6'h00, 1'b1, 1'b0, e_rst());
    rst = 1'b0;

    i_j();                 // normal fetch resumes after release
    cyc("final fetch", op_j, 6'h00, 1'b0, 1'b0, e_fetch(1'b0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left in scoreboard, 0 required", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
